// File: rtl/line_pkg.sv
// Shared definitions for the line sweep sequencer: screen geometry,
// coordinate types, sequencer states and the sweep position advance rule.
package line_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [9:0] coord_x_t;
  typedef logic [8:0] coord_y_t;

  typedef enum logic [2:0] {
    INIT,
    HOLD,
    ERASE_ISSUE,
    ERASE_WAIT,
    DRAW_ISSUE,
    DRAW_WAIT,
    CLR_ISSUE,
    CLR_WAIT
  } seq_state_t;

  // Next sweep column: wraps to 0 once the step would pass x_max.
  // The sum is formed one bit wider than a column so it cannot overflow.
  function automatic coord_x_t advance_pos(input coord_x_t pos, input int step, input int x_max);
    logic [10:0] sum;
    sum = {1'b0, pos} + 11'(step);
    if (sum > 11'(x_max)) begin
      return '0;
    end
    return sum[9:0];
  endfunction

endpackage

// File: rtl/sweep_position.sv
// Sweep position register: steps forward after each erase and snaps back
// to column 0 when a full-screen clear finishes.
module sweep_position
  import line_pkg::*;
#(
  parameter int X_MAX = SCREEN_W - 1,
  parameter int STEP  = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     advance,
  input  logic     restart,
  output coord_x_t pos
);

  // Restart wins over advance; the two never coincide in normal operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos <= '0;
    end else if (restart) begin
      pos <= '0;
    end else if (advance) begin
      pos <= advance_pos(pos, STEP, X_MAX);
    end
  end

endmodule

// File: rtl/line_sweep_sequencer.sv
// Command source for the line drawer: animates a sweeping line by erasing
// the old line and drawing the next one on each accepted tick, and blanks
// the whole screen column by column on a clear request.
module line_sweep_sequencer
  import line_pkg::*;
#(
  parameter int X_MAX = SCREEN_W - 1,
  parameter int Y_MAX = SCREEN_H - 1,
  parameter int STEP  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_tick,
  input  logic        en,
  input  logic        clear_req,
  input  logic        ld_done,
  output logic        ld_start,
  output coord_x_t    x0,
  output coord_x_t    x1,
  output coord_y_t    y0,
  output coord_y_t    y1,
  output logic        pixel_color,
  output logic        busy,
  output logic [15:0] lines_drawn
);

  localparam coord_x_t X_MAX_X = coord_x_t'(X_MAX);
  localparam coord_y_t Y_MAX_Y = coord_y_t'(Y_MAX);

  seq_state_t state;
  seq_state_t next_state;
  coord_x_t   pos;
  coord_x_t   pos_adv;
  coord_x_t   clr_col;
  logic       pend_tick;
  logic       pend_clr;
  logic       drawn;
  logic       tick_now;
  logic       tick_any;
  logic       clr_any;
  logic       erase_done;
  logic       draw_done;
  logic       clr_done;
  logic       clr_last;
  logic       hold_to_clr;
  logic       hold_to_sweep;
  logic       load;
  coord_x_t   load_x0;
  coord_x_t   load_x1;
  logic       load_color;

  assign tick_now      = step_tick & en;
  assign tick_any      = pend_tick | tick_now;
  assign clr_any       = pend_clr | clear_req;
  assign erase_done    = (state == ERASE_WAIT) && ld_done;
  assign draw_done     = (state == DRAW_WAIT) && ld_done;
  assign clr_done      = (state == CLR_WAIT) && ld_done;
  assign clr_last      = clr_done && (clr_col >= X_MAX_X);
  assign hold_to_clr   = (state == HOLD) && clr_any;
  assign hold_to_sweep = (state == HOLD) && !clr_any && tick_any;
  assign pos_adv       = advance_pos(pos, STEP, X_MAX);
  assign y0            = '0;

  sweep_position #(
    .X_MAX(X_MAX),
    .STEP (STEP)
  ) u_sweep_position (
    .clk    (clk),
    .reset  (reset),
    .advance(erase_done),
    .restart(clr_last),
    .pos    (pos)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus the endpoints/colour to latch when entering an issue state.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_x0    = pos;
    load_x1    = X_MAX_X - pos;
    load_color = 1'b0;
    case (state)
      INIT: begin
        next_state = DRAW_ISSUE;
        load       = 1'b1;
        load_color = 1'b1;
      end
      HOLD: begin
        if (clr_any) begin
          next_state = CLR_ISSUE;
          load       = 1'b1;
          load_x0    = '0;
          load_x1    = '0;
        end else if (tick_any) begin
          load = 1'b1;
          if (drawn) begin
            next_state = ERASE_ISSUE;
          end else begin
            next_state = DRAW_ISSUE;
            load_color = 1'b1;
          end
        end
      end
      ERASE_ISSUE: next_state = ERASE_WAIT;
      ERASE_WAIT: begin
        if (ld_done) begin
          next_state = DRAW_ISSUE;
          load       = 1'b1;
          load_x0    = pos_adv;
          load_x1    = X_MAX_X - pos_adv;
          load_color = 1'b1;
        end
      end
      DRAW_ISSUE: next_state = DRAW_WAIT;
      DRAW_WAIT: begin
        if (ld_done) begin
          next_state = HOLD;
        end
      end
      CLR_ISSUE: next_state = CLR_WAIT;
      CLR_WAIT: begin
        if (ld_done) begin
          load = 1'b1;
          if (clr_col < X_MAX_X) begin
            next_state = CLR_ISSUE;
            load_x0    = clr_col + 10'd1;
            load_x1    = clr_col + 10'd1;
          end else begin
            next_state = DRAW_ISSUE;
            load_x0    = '0;
            load_x1    = X_MAX_X;
            load_color = 1'b1;
          end
        end
      end
      default: next_state = INIT;
    endcase
  end

  // Registered outputs to the line drawer, held steady until the next issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      x0          <= '0;
      x1          <= '0;
      y1          <= '0;
      pixel_color <= 1'b0;
      ld_start    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (load) begin
        x0          <= load_x0;
        x1          <= load_x1;
        y1          <= Y_MAX_Y;
        pixel_color <= load_color;
      end
      ld_start <= (next_state == ERASE_ISSUE) || (next_state == DRAW_ISSUE) ||
                  (next_state == CLR_ISSUE);
      busy     <= (next_state != HOLD);
    end
  end

  // Pending requests, clear column, drawn flag and completed-line counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_tick   <= 1'b0;
      pend_clr    <= 1'b0;
      drawn       <= 1'b0;
      clr_col     <= '0;
      lines_drawn <= '0;
    end else begin
      if (hold_to_sweep) begin
        pend_tick <= 1'b0;
      end else if (tick_now) begin
        pend_tick <= 1'b1;
      end

      if (clr_last) begin
        pend_clr <= 1'b0;
      end else if (clear_req && (state != CLR_ISSUE) && (state != CLR_WAIT)) begin
        pend_clr <= 1'b1;
      end

      if (hold_to_clr) begin
        clr_col <= '0;
      end else if (clr_done && !clr_last) begin
        clr_col <= clr_col + 10'd1;
      end

      if (erase_done || clr_last) begin
        drawn <= 1'b0;
      end else if (draw_done) begin
        drawn <= 1'b1;
      end

      if (draw_done) begin
        lines_drawn <= lines_drawn + 16'd1;
      end
    end
  end

endmodule
